// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg
// Shared definitions for the SPI-attached RAM slave: the two-bit command
// codes carried in every frame and the slave FSM state encoding.
// Ports: none (package).

package spi_ram_pkg;

  // Command field, sent MSB first right after the start cycle
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    RX      = 3'd2,
    RD_WAIT = 3'd3,
    TX      = 3'd4
  } state_e;

  localparam int CMD_BITS = 2;

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem
// Word-wide storage for spi_ram_burst. One synchronous write port and one
// registered read port. Addresses at or above MEM_DEPTH are guarded: writes
// are dropped and reads return zero.
// Ports:
//   clk_i      clock, rising edge
//   wrEn_i     write strobe
//   wrAddr_i   write address
//   wrData_i   write word
//   rdEn_i     read strobe; rdData_o updates only when high
//   rdAddr_i   read address
//   rdData_o   registered read word, held between reads

module spi_ram_mem #(
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  wrEn_i,
  input  logic [ADDR_SIZE-1:0]  wrAddr_i,
  input  logic [DATA_WIDTH-1:0] wrData_i,
  input  logic                  rdEn_i,
  input  logic [ADDR_SIZE-1:0]  rdAddr_i,
  output logic [DATA_WIDTH-1:0] rdData_o
);

  localparam logic [ADDR_SIZE:0] DEPTH_LIMIT = (ADDR_SIZE + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic                  wrInRange;
  logic                  rdInRange;

  // Extra leading zero so the compare also works when MEM_DEPTH == 2**ADDR_SIZE
  assign wrInRange = ({1'b0, wrAddr_i} < DEPTH_LIMIT);
  assign rdInRange = ({1'b0, rdAddr_i} < DEPTH_LIMIT);

  // Storage is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (wrEn_i && wrInRange) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  // The read word is captured once and then held, so later writes to the
  // same address cannot disturb a word already being shifted out
  always_ff @(posedge clk_i) begin
    if (rdEn_i) begin
      rdData_o <= rdInRange ? mem_q[rdAddr_i] : '0;
    end
  end

endmodule

// File: rtl/spi_ram_burst.sv
// spi_ram_burst
// SPI-style serial slave in front of a small RAM. Each frame is a start
// cycle, a 2-bit command and a DATA_WIDTH payload, all MSB first on MOSI
// while SS_n is low. Commands set the write/read address, write a word, or
// read a word back on MISO. Addresses optionally auto-increment.
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   MOSI       serial data in, MSB first
//   SS_n       slave select, active low; high ends or aborts a frame
//   MISO       serial read data out, MSB first, zero outside TX
//   frame_err  one-cycle pulse after a frame is aborted

module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AUTO_INC   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO,
  output logic frame_err
);

  localparam int                 CNT_W     = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]   LAST_CMD  = CNT_W'(CMD_BITS - 1);
  localparam logic [ADDR_SIZE:0] LAST_ADDR = (ADDR_SIZE + 1)'(MEM_DEPTH - 1);

  state_e                state_q,     state_d;
  logic [CNT_W-1:0]      bitCnt_q,    bitCnt_d;
  logic [1:0]            cmdShift_q,  cmdShift_d;
  logic [DATA_WIDTH-1:0] rxShift_q,   rxShift_d;
  logic                  commit_q,    commit_d;
  cmd_e                  commitCmd_q, commitCmd_d;
  logic                  done_q,      done_d;
  logic [ADDR_SIZE-1:0]  wrAddr_q,    wrAddr_d;
  logic [ADDR_SIZE-1:0]  rdAddr_q,    rdAddr_d;
  logic                  frameErr_q,  frameErr_d;

  logic                  memWrEn;
  logic                  memRdEn;
  logic [DATA_WIDTH-1:0] memRdData;
  logic [DATA_WIDTH-1:0] txWord;

  // Out-of-range addresses also fall into the wrap branch
  function automatic logic [ADDR_SIZE-1:0] incAddr(input logic [ADDR_SIZE-1:0] a);
    if ({1'b0, a} >= LAST_ADDR) begin
      return '0;
    end
    return a + ADDR_SIZE'(1);
  endfunction

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .wrEn_i  (memWrEn),
    .wrAddr_i(wrAddr_q),
    .wrData_i(rxShift_q),
    .rdEn_i  (memRdEn),
    .rdAddr_i(rdAddr_q),
    .rdData_o(memRdData)
  );

  // A completed frame is applied one cycle later from the held payload;
  // gating with rst_n keeps a reset on that cycle from writing memory
  assign memWrEn = rst_n && commit_q && (commitCmd_q == WR_DATA);

  assign txWord    = memRdData << bitCnt_q;
  assign MISO      = (state_q == TX) ? txWord[DATA_WIDTH-1] : 1'b0;
  assign frame_err = frameErr_q;

  // Next-state logic. done_q blocks a new frame after a completed
  // address/write frame until SS_n has been seen high again.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    cmdShift_d  = cmdShift_q;
    rxShift_d   = rxShift_q;
    commit_d    = 1'b0;
    commitCmd_d = commitCmd_q;
    done_d      = done_q;
    wrAddr_d    = wrAddr_q;
    rdAddr_d    = rdAddr_q;
    frameErr_d  = 1'b0;
    memRdEn     = 1'b0;

    if (commit_q) begin
      case (commitCmd_q)
        WR_ADDR: wrAddr_d = rxShift_q[ADDR_SIZE-1:0];
        WR_DATA: if (AUTO_INC != 0) wrAddr_d = incAddr(wrAddr_q);
        RD_ADDR: rdAddr_d = rxShift_q[ADDR_SIZE-1:0];
        default: ;
      endcase
    end

    if (state_q != IDLE && SS_n) begin
      state_d    = IDLE;
      bitCnt_d   = '0;
      frameErr_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (SS_n) begin
            done_d = 1'b0;
          end else if (!done_q) begin
            state_d  = CMD;
            bitCnt_d = '0;
          end
        end
        CMD: begin
          cmdShift_d = {cmdShift_q[0], MOSI};
          if (bitCnt_q == LAST_CMD) begin
            state_d  = RX;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end
        RX: begin
          rxShift_d = {rxShift_q[DATA_WIDTH-2:0], MOSI};
          if (bitCnt_q == LAST_BIT) begin
            bitCnt_d = '0;
            if (cmd_e'(cmdShift_q) == RD_DATA) begin
              state_d = RD_WAIT;
            end else begin
              state_d     = IDLE;
              commit_d    = 1'b1;
              commitCmd_d = cmd_e'(cmdShift_q);
              done_d      = 1'b1;
            end
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end
        RD_WAIT: begin
          memRdEn  = 1'b1;
          state_d  = TX;
          bitCnt_d = '0;
        end
        TX: begin
          if (bitCnt_q == LAST_BIT) begin
            state_d  = IDLE;
            bitCnt_d = '0;
            if (AUTO_INC != 0) rdAddr_d = incAddr(rdAddr_q);
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      cmdShift_q  <= '0;
      rxShift_q   <= '0;
      commit_q    <= 1'b0;
      commitCmd_q <= WR_ADDR;
      done_q      <= 1'b0;
      wrAddr_q    <= '0;
      rdAddr_q    <= '0;
      frameErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      cmdShift_q  <= cmdShift_d;
      rxShift_q   <= rxShift_d;
      commit_q    <= commit_d;
      commitCmd_q <= commitCmd_d;
      done_q      <= done_d;
      wrAddr_q    <= wrAddr_d;
      rdAddr_q    <= rdAddr_d;
      frameErr_q  <= frameErr_d;
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst
// Self-checking bench for spi_ram_burst. Three instances cover the default
// configuration, fixed addressing (AUTO_INC=0) and a non power-of-two depth
// (MEM_DEPTH=200). Directed frames come from a table, corner cases are
// hand-written, and a random phase is checked against a frame-level model.

module tb_spi_ram_burst;

  localparam logic [1:0] C_WR_ADDR = 2'b00;
  localparam logic [1:0] C_WR_DATA = 2'b01;
  localparam logic [1:0] C_RD_ADDR = 2'b10;
  localparam logic [1:0] C_RD_DATA = 2'b11;

  logic       clk = 1'b0;
  logic       rstN;
  logic [2:0] mosi;
  logic [2:0] ssN;
  wire  [2:0] miso;
  wire  [2:0] ferr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    logic [1:0] cmd;
    logic [7:0] payload;
    bit         chk;
    logic [7:0] expWord;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // Frame-level reference model
  int         mDepth [3] = '{256, 256, 200};
  int         mAuto  [3] = '{1, 0, 1};
  logic [7:0] mMem   [3][256];
  bit         mValid [3][256];
  int         mWr    [3];
  int         mRd    [3];

  spi_ram_burst #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_WIDTH(8), .AUTO_INC(1)) dut0 (
    .clk(clk), .rst_n(rstN), .MOSI(mosi[0]), .SS_n(ssN[0]), .MISO(miso[0]), .frame_err(ferr[0]));
  spi_ram_burst #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_WIDTH(8), .AUTO_INC(0)) dut1 (
    .clk(clk), .rst_n(rstN), .MOSI(mosi[1]), .SS_n(ssN[1]), .MISO(miso[1]), .frame_err(ferr[1]));
  spi_ram_burst #(.MEM_DEPTH(200), .ADDR_SIZE(8), .DATA_WIDTH(8), .AUTO_INC(1)) dut2 (
    .clk(clk), .rst_n(rstN), .MOSI(mosi[2]), .SS_n(ssN[2]), .MISO(miso[2]), .frame_err(ferr[2]));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%02h expected=%02h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 3; d++) begin
      mWr[d] = 0;
      mRd[d] = 0;
    end
  endtask

  task automatic modelApply(input int d, input logic [1:0] cmd, input logic [7:0] payload,
                            output logic [7:0] expWord, output bit known);
    expWord = 8'h00;
    known   = 1'b0;
    case (cmd)
      C_WR_ADDR: mWr[d] = int'(payload);
      C_WR_DATA: begin
        if (mWr[d] < mDepth[d]) begin
          mMem[d][mWr[d]]   = payload;
          mValid[d][mWr[d]] = 1'b1;
        end
        if (mAuto[d] != 0) mWr[d] = (mWr[d] + 1 >= mDepth[d]) ? 0 : mWr[d] + 1;
      end
      C_RD_ADDR: mRd[d] = int'(payload);
      default: begin
        if (mRd[d] >= mDepth[d]) begin
          known = 1'b1;
        end else begin
          expWord = mMem[d][mRd[d]];
          known   = mValid[d][mRd[d]];
        end
        if (mAuto[d] != 0) mRd[d] = (mRd[d] + 1 >= mDepth[d]) ? 0 : mRd[d] + 1;
      end
    endcase
  endtask

  task automatic abortFrame(input int d, input string name);
    ssN[d]  = 1'b1;
    mosi[d] = 1'b0;
    stepClk();
    checkOutput({name, "_pulse"}, {7'b0, ferr[d]}, 8'd1);
    checkOutput({name, "_miso"}, {7'b0, miso[d]}, 8'd0);
    stepClk();
    checkOutput({name, "_clear"}, {7'b0, ferr[d]}, 8'd0);
  endtask

  // Drives one complete frame; abortRx/abortTx give the bit index at which
  // SS_n is raised early (-1 for none)
  task automatic applyStimulus(input int d, input logic [1:0] cmd, input logic [7:0] payload,
                               input int abortRx, input int abortTx, output logic [7:0] rxWord);
    logic misoIdle;
    logic errSeen;
    misoIdle = 1'b0;
    errSeen  = 1'b0;
    rxWord   = 8'h00;
    ssN[d]   = 1'b0;
    mosi[d]  = 1'b0;
    stepClk();
    misoIdle |= miso[d];
    errSeen  |= ferr[d];
    for (int i = 0; i < 2; i++) begin
      mosi[d] = cmd[1-i];
      stepClk();
      misoIdle |= miso[d];
      errSeen  |= ferr[d];
    end
    for (int i = 0; i < 8; i++) begin
      if (i == abortRx) begin
        abortFrame(d, "abort_rx");
        return;
      end
      mosi[d] = payload[7-i];
      stepClk();
      misoIdle |= miso[d];
      errSeen  |= ferr[d];
    end
    if (cmd == C_RD_DATA) begin
      mosi[d] = 1'b0;
      stepClk();
      for (int i = 0; i < 8; i++) begin
        if (i == abortTx) begin
          abortFrame(d, "abort_tx");
          return;
        end
        rxWord[7-i] = miso[d];
        stepClk();
        errSeen |= ferr[d];
      end
    end
    ssN[d]  = 1'b1;
    mosi[d] = 1'b0;
    stepClk();
    misoIdle |= miso[d];
    errSeen  |= ferr[d];
    stepClk();
    misoIdle |= miso[d];
    errSeen  |= ferr[d];
    checkOutput("frame_err_quiet", {7'b0, errSeen}, 8'd0);
    checkOutput("miso_outside_tx", {7'b0, misoIdle}, 8'd0);
  endtask

  task automatic doFrame(input int d, input logic [1:0] cmd, input logic [7:0] payload, input string name);
    logic [7:0] word;
    logic [7:0] expWord;
    bit         known;
    applyStimulus(d, cmd, payload, -1, -1, word);
    modelApply(d, cmd, payload, expWord, known);
    if (cmd == C_RD_DATA && known) checkOutput(name, word, expWord);
  endtask

  function automatic void addVec(input int d, input logic [1:0] cmd, input logic [7:0] payload,
                                 input bit chk, input logic [7:0] expWord, input string name);
    vec_t v;
    v.dut = d; v.cmd = cmd; v.payload = payload; v.chk = chk; v.expWord = expWord; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] pickAddr(input int d);
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0 && d == 0) return 8'($urandom_range(252, 255));
    if (r == 0 && d == 2) return 8'($urandom_range(196, 203));
    return 8'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [7:0] word;
    logic [7:0] expWord;
    bit         known;
    logic       seen;
    logic       errSeen;

    rstN = 1'b0;
    ssN  = 3'b111;
    mosi = 3'b000;
    modelReset();
    repeat (3) stepClk();
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset_miso", {7'b0, miso[d]}, 8'd0);
      checkOutput("reset_frame_err", {7'b0, ferr[d]}, 8'd0);
    end
    rstN = 1'b1;
    stepClk();

    // Directed table: basic readback, burst wrap, fixed address, depth 200
    addVec(0, C_WR_ADDR, 8'h10, 0, 8'h00, "t_wa10");
    addVec(0, C_WR_DATA, 8'hA5, 0, 8'h00, "t_wdA5");
    addVec(0, C_RD_ADDR, 8'h10, 0, 8'h00, "t_ra10");
    addVec(0, C_RD_DATA, 8'h00, 1, 8'hA5, "rd_basic_A5");
    addVec(0, C_WR_ADDR, 8'hFF, 0, 8'h00, "t_waFF");
    addVec(0, C_WR_DATA, 8'h11, 0, 8'h00, "t_wd11");
    addVec(0, C_WR_DATA, 8'h22, 0, 8'h00, "t_wd22");
    addVec(0, C_RD_ADDR, 8'hFF, 0, 8'h00, "t_raFF");
    addVec(0, C_RD_DATA, 8'h00, 1, 8'h11, "rd_burst_FF");
    addVec(0, C_RD_DATA, 8'h00, 1, 8'h22, "rd_burst_wrap00");
    addVec(1, C_WR_ADDR, 8'h06, 0, 8'h00, "t_wa06");
    addVec(1, C_WR_DATA, 8'h5C, 0, 8'h00, "t_wd5C");
    addVec(1, C_WR_ADDR, 8'h05, 0, 8'h00, "t_wa05");
    addVec(1, C_WR_DATA, 8'h33, 0, 8'h00, "t_wd33");
    addVec(1, C_WR_DATA, 8'h44, 0, 8'h00, "t_wd44");
    addVec(1, C_RD_ADDR, 8'h05, 0, 8'h00, "t_ra05");
    addVec(1, C_RD_DATA, 8'h00, 1, 8'h44, "rd_fixed_05");
    addVec(1, C_RD_DATA, 8'h00, 1, 8'h44, "rd_fixed_05_again");
    addVec(1, C_RD_ADDR, 8'h06, 0, 8'h00, "t_ra06");
    addVec(1, C_RD_DATA, 8'h00, 1, 8'h5C, "rd_fixed_06_untouched");
    addVec(2, C_WR_ADDR, 8'h00, 0, 8'h00, "t_wa00");
    addVec(2, C_WR_DATA, 8'h9A, 0, 8'h00, "t_wd9A");
    addVec(2, C_WR_ADDR, 8'hC8, 0, 8'h00, "t_waC8");
    addVec(2, C_WR_DATA, 8'h77, 0, 8'h00, "t_wd77_dropped");
    addVec(2, C_WR_DATA, 8'h3C, 0, 8'h00, "t_wd3C_at0");
    addVec(2, C_RD_ADDR, 8'hC8, 0, 8'h00, "t_raC8");
    addVec(2, C_RD_DATA, 8'h00, 1, 8'h00, "rd_out_of_range");
    addVec(2, C_RD_DATA, 8'h00, 1, 8'h3C, "rd_wrap_after_oor");
    addVec(2, C_WR_ADDR, 8'hC7, 0, 8'h00, "t_waC7");
    addVec(2, C_WR_DATA, 8'hE1, 0, 8'h00, "t_wdE1");
    addVec(2, C_WR_DATA, 8'h4B, 0, 8'h00, "t_wd4B_wrap");
    addVec(2, C_RD_ADDR, 8'hC7, 0, 8'h00, "t_raC7");
    addVec(2, C_RD_DATA, 8'h00, 1, 8'hE1, "rd_last_word");
    addVec(2, C_RD_DATA, 8'h00, 1, 8'h4B, "rd_last_wrap");

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].dut, vecs[k].cmd, vecs[k].payload, -1, -1, word);
      modelApply(vecs[k].dut, vecs[k].cmd, vecs[k].payload, expWord, known);
      if (vecs[k].chk) checkOutput(vecs[k].name, word, vecs[k].expWord);
    end

    // Abort mid-payload: target word and wr_addr must survive
    doFrame(0, C_WR_ADDR, 8'h40, "");
    doFrame(0, C_WR_DATA, 8'h12, "");
    doFrame(0, C_WR_ADDR, 8'h40, "");
    applyStimulus(0, C_WR_DATA, 8'hFF, 4, -1, word);
    doFrame(0, C_RD_ADDR, 8'h40, "");
    doFrame(0, C_RD_DATA, 8'h00, "abort_word_kept");
    doFrame(0, C_WR_DATA, 8'h34, "");
    doFrame(0, C_RD_ADDR, 8'h40, "");
    doFrame(0, C_RD_DATA, 8'h00, "abort_wraddr_kept");

    // Abort during TX must not advance rd_addr
    doFrame(0, C_RD_ADDR, 8'h10, "");
    applyStimulus(0, C_RD_DATA, 8'h00, -1, 3, word);
    doFrame(0, C_RD_DATA, 8'h00, "tx_abort_rdaddr_kept");

    // Holding SS_n low after a completed frame must not start another
    ssN[0] = 1'b0; mosi[0] = 1'b0; stepClk();
    mosi[0] = 1'b0; stepClk();
    mosi[0] = 1'b0; stepClk();
    for (int i = 0; i < 8; i++) begin
      mosi[0] = 8'h20 >> (7 - i);
      stepClk();
    end
    seen = 1'b0;
    errSeen = 1'b0;
    mosi[0] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      stepClk();
      seen    |= miso[0];
      errSeen |= ferr[0];
    end
    ssN[0] = 1'b1; mosi[0] = 1'b0;
    stepClk();
    errSeen |= ferr[0];
    stepClk();
    checkOutput("hold_low_no_restart_err", {7'b0, errSeen}, 8'd0);
    checkOutput("hold_low_no_restart_miso", {7'b0, seen}, 8'd0);
    modelApply(0, C_WR_ADDR, 8'h20, expWord, known);
    doFrame(0, C_WR_DATA, 8'h6E, "");
    doFrame(0, C_RD_ADDR, 8'h20, "");
    doFrame(0, C_RD_DATA, 8'h00, "hold_low_wraddr");

    // Reset in the middle of TX
    doFrame(0, C_RD_ADDR, 8'h00, "");
    ssN[0] = 1'b0; mosi[0] = 1'b0; stepClk();
    mosi[0] = 1'b1; stepClk();
    stepClk();
    mosi[0] = 1'b0;
    for (int i = 0; i < 8; i++) stepClk();
    stepClk();
    for (int i = 0; i < 3; i++) stepClk();
    rstN = 1'b0;
    stepClk();
    checkOutput("rst_tx_miso", {7'b0, miso[0]}, 8'd0);
    checkOutput("rst_tx_frame_err", {7'b0, ferr[0]}, 8'd0);
    rstN = 1'b1;
    ssN[0] = 1'b1;
    stepClk();
    checkOutput("rst_tx_after_err", {7'b0, ferr[0]}, 8'd0);
    checkOutput("rst_tx_after_miso", {7'b0, miso[0]}, 8'd0);
    stepClk();
    modelReset();
    doFrame(0, C_RD_DATA, 8'h00, "rst_rdaddr_zero");
    doFrame(2, C_RD_DATA, 8'h00, "rst_rdaddr_zero_d2");

    // Randomised frames against the model
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 40; n++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 1) begin
          doFrame(d, C_WR_ADDR, pickAddr(d), "");
        end else if (r <= 4) begin
          doFrame(d, C_WR_DATA, 8'($urandom_range(0, 255)), "");
        end else if (r == 5) begin
          doFrame(d, C_RD_ADDR, pickAddr(d), "");
        end else if (r <= 8) begin
          doFrame(d, C_RD_DATA, 8'($urandom_range(0, 255)), "rand_read");
        end else begin
          applyStimulus(d, C_WR_DATA, 8'($urandom_range(0, 255)),
                        int'($urandom_range(0, 7)), -1, word);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
